// File: rtl/game_pkg.sv
// Shared game types and frame-timing constants for the player and monster controllers.
package game_pkg;

  localparam int LIVES_W     = 2;
  localparam int FRAME_CNT_W = 8;

  // Default frame budgets; monster controllers reuse the same timebase.
  localparam int START_LIVES_DEF    = 3;
  localparam int DEATH_FRAMES_DEF   = 48;
  localparam int ANIM_STEP_DEF      = 8;
  localparam int RESPAWN_FRAMES_DEF = 30;
  localparam int INVULN_FRAMES_DEF  = 90;
  localparam int BLINK_HALF_DEF     = 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PLAYING      = 3'd1,
    DYING        = 3'd2,
    RESPAWN_WAIT = 3'd3,
    INVULN       = 3'd4,
    GAME_OVER    = 3'd5
  } life_state_t;

endpackage

// File: rtl/frame_timer.sv
// startOfFrame-driven counter with clear, terminal-count detect and a blink
// phase bit taken from the next count value so registered outputs line up.
module frame_timer
  import game_pkg::*;
#(
  parameter int BLINK_HALF = BLINK_HALF_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startOfFrame,
  input  logic                   clear,
  input  logic [FRAME_CNT_W-1:0] lastFrame,
  output logic [FRAME_CNT_W-1:0] frameCntNext,
  output logic                   termHit,
  output logic                   blinkNext
);

  logic [FRAME_CNT_W-1:0] frameCnt;

  function automatic logic blinkOf(input logic [FRAME_CNT_W-1:0] c);
    logic [FRAME_CNT_W-1:0] q;
    q = c / FRAME_CNT_W'(BLINK_HALF);
    return q[0];
  endfunction

  // Clear has priority so a frame tick coinciding with a state change is dropped.
  always_comb begin
    frameCntNext = frameCnt;
    if (clear)
      frameCntNext = '0;
    else if (startOfFrame)
      frameCntNext = frameCnt + FRAME_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      frameCnt <= '0;
    else
      frameCnt <= frameCntNext;
  end

  assign termHit   = startOfFrame && (frameCnt == lastFrame);
  assign blinkNext = blinkOf(frameCntNext);

endmodule

// File: rtl/player_life_ctrl.sv
// Player life sequencer: play, death animation, hidden respawn wait,
// blinking invulnerability and game over, with lives bookkeeping.
module player_life_ctrl
  import game_pkg::*;
#(
  parameter int START_LIVES    = START_LIVES_DEF,
  parameter int DEATH_FRAMES   = DEATH_FRAMES_DEF,
  parameter int ANIM_STEP      = ANIM_STEP_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int INVULN_FRAMES  = INVULN_FRAMES_DEF,
  parameter int BLINK_HALF     = BLINK_HALF_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               player_died,
  input  logic [3:0]         arrows_in,
  output logic [3:0]         arrows_out,
  output logic               player_respawn,
  output logic               player_visible,
  output logic [2:0]         death_image,
  output logic [LIVES_W-1:0] lives,
  output logic               invulnerable,
  output logic               game_over
);

  life_state_t            state, stateNext;
  logic [FRAME_CNT_W-1:0] lastFrame;
  logic [FRAME_CNT_W-1:0] frameCntNext;
  logic                   termHit;
  logic                   blinkNext;
  logic                   stateChange;
  logic                   arrowsEn;

  function automatic logic [LIVES_W-1:0] decSat(input logic [LIVES_W-1:0] l);
    return (l == '0) ? '0 : l - LIVES_W'(1);
  endfunction

  function automatic logic [2:0] imageOf(input logic [FRAME_CNT_W-1:0] c);
    logic [FRAME_CNT_W-1:0] q;
    q = c / FRAME_CNT_W'(ANIM_STEP);
    return (q > FRAME_CNT_W'(7)) ? 3'd7 : q[2:0];
  endfunction

  function automatic logic visibleOf(input life_state_t s, input logic blink);
    case (s)
      PLAYING, DYING: return 1'b1;
      INVULN:         return ~blink;
      default:        return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (state)
      DYING:        lastFrame = FRAME_CNT_W'(DEATH_FRAMES - 1);
      RESPAWN_WAIT: lastFrame = FRAME_CNT_W'(RESPAWN_FRAMES - 1);
      INVULN:       lastFrame = FRAME_CNT_W'(INVULN_FRAMES - 1);
      default:      lastFrame = '1;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, GAME_OVER: if (start_game)  stateNext = INVULN;
      PLAYING:         if (player_died) stateNext = DYING;
      DYING:           if (termHit)     stateNext = (lives == '0) ? GAME_OVER : RESPAWN_WAIT;
      RESPAWN_WAIT:    if (termHit)     stateNext = INVULN;
      INVULN:          if (termHit)     stateNext = PLAYING;
      default:                          stateNext = IDLE;
    endcase
  end

  assign stateChange = (stateNext != state);

  frame_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_frameTimer (
    .clk         (clk),
    .rst         (resetN),
    .startOfFrame(startOfFrame),
    .clear       (stateChange),
    .lastFrame   (lastFrame),
    .frameCntNext(frameCntNext),
    .termHit     (termHit),
    .blinkNext   (blinkNext)
  );

  // Outputs are decoded from the next state/count so they settle one edge after the cause.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state          <= IDLE;
      lives          <= '0;
      player_respawn <= 1'b0;
      player_visible <= 1'b0;
      death_image    <= '0;
      invulnerable   <= 1'b0;
      game_over      <= 1'b0;
      arrowsEn       <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == PLAYING && stateNext == DYING)
        lives <= decSat(lives);
      else if ((state == IDLE || state == GAME_OVER) && stateNext == INVULN)
        lives <= LIVES_W'(START_LIVES);
      // Every entry into INVULN comes from a (re)spawn, so the pulse keys off that entry.
      player_respawn <= (stateNext == INVULN) && (state != INVULN);
      player_visible <= visibleOf(stateNext, blinkNext);
      death_image    <= (stateNext == DYING) ? imageOf(frameCntNext) : 3'd0;
      invulnerable   <= (stateNext == INVULN);
      game_over      <= (stateNext == GAME_OVER);
      arrowsEn       <= (stateNext == PLAYING) || (stateNext == INVULN);
    end
  end

  assign arrows_out = arrows_in & {4{arrowsEn}};

endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed bench for player_life_ctrl: start, death cycle, ignored events,
// game over/restart, same-cycle death+frame, and mid-death reset.
module tb_player_life_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       start_game = 1'b0;
  logic       player_died = 1'b0;
  logic [3:0] arrows_in = 4'hF;
  logic [3:0] arrows_out;
  logic       player_respawn;
  logic       player_visible;
  logic [2:0] death_image;
  logic [1:0] lives;
  logic       invulnerable;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  player_life_ctrl dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .start_game    (start_game),
    .player_died   (player_died),
    .arrows_in     (arrows_in),
    .arrows_out    (arrows_out),
    .player_respawn(player_respawn),
    .player_visible(player_visible),
    .death_image   (death_image),
    .lives         (lives),
    .invulnerable  (invulnerable),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sofPulse(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic pulseStart();
    start_game = 1'b1;
    step();
    start_game = 1'b0;
  endtask

  task automatic pulseDied();
    player_died = 1'b1;
    step();
    player_died = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    arrows_in = 4'hF;
    step(); step();
    resetN = 1'b0;
    step();
    vectors++; if (lives !== 2'd0) begin miscompares++; $display("FAIL reset_lives: got %0d required 0", lives); end
    vectors++; if ({player_respawn, player_visible, invulnerable, game_over} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b required 0000", {player_respawn, player_visible, invulnerable, game_over}); end
    vectors++; if (death_image !== 3'd0) begin miscompares++; $display("FAIL reset_image: got %0d required 0", death_image); end
    vectors++; if (arrows_out !== 4'h0) begin miscompares++; $display("FAIL reset_arrows: got %h required 0", arrows_out); end
  endtask

  task automatic test_start();
    pulseStart();
    vectors++; if (player_respawn !== 1'b1) begin miscompares++; $display("FAIL start_respawn: got %b required 1", player_respawn); end
    vectors++; if (lives !== 2'd3) begin miscompares++; $display("FAIL start_lives: got %0d required 3", lives); end
    vectors++; if (invulnerable !== 1'b1) begin miscompares++; $display("FAIL start_invuln: got %b required 1", invulnerable); end
    vectors++; if (player_visible !== 1'b1) begin miscompares++; $display("FAIL start_visible: got %b required 1", player_visible); end
    vectors++; if (arrows_out !== 4'hF) begin miscompares++; $display("FAIL start_arrows: got %h required f", arrows_out); end
    step();
    vectors++; if (player_respawn !== 1'b0) begin miscompares++; $display("FAIL start_respawn_width: got %b required 0", player_respawn); end
    sofPulse(4);
    vectors++; if (player_visible !== 1'b0) begin miscompares++; $display("FAIL blink_off: got %b required 0", player_visible); end
    sofPulse(4);
    vectors++; if (player_visible !== 1'b1) begin miscompares++; $display("FAIL blink_on: got %b required 1", player_visible); end
    sofPulse(81);
    vectors++; if (invulnerable !== 1'b1) begin miscompares++; $display("FAIL invuln_89: got %b required 1", invulnerable); end
    sofPulse(1);
    arrows_in = 4'b1010;
    #1;
    vectors++; if (invulnerable !== 1'b0) begin miscompares++; $display("FAIL invuln_90: got %b required 0", invulnerable); end
    vectors++; if (player_visible !== 1'b1) begin miscompares++; $display("FAIL playing_visible: got %b required 1", player_visible); end
    vectors++; if (arrows_out !== 4'b1010) begin miscompares++; $display("FAIL playing_arrows: got %b required 1010", arrows_out); end
  endtask

  task automatic test_death();
    pulseDied();
    vectors++; if (lives !== 2'd2) begin miscompares++; $display("FAIL death_lives: got %0d required 2", lives); end
    vectors++; if (arrows_out !== 4'h0) begin miscompares++; $display("FAIL death_arrows: got %h required 0", arrows_out); end
    vectors++; if (player_visible !== 1'b1 || death_image !== 3'd0) begin miscompares++;
      $display("FAIL death_enter: got vis=%b img=%0d required vis=1 img=0", player_visible, death_image); end
    for (int k = 1; k <= 5; k++) begin
      sofPulse(8);
      vectors++; if (death_image !== 3'(k)) begin miscompares++; $display("FAIL death_image_%0d: got %0d required %0d", k, death_image, k); end
    end
    sofPulse(7);
    vectors++; if (death_image !== 3'd5 || game_over !== 1'b0) begin miscompares++;
      $display("FAIL death_47: got img=%0d go=%b required img=5 go=0", death_image, game_over); end
    sofPulse(1);
    vectors++; if (player_visible !== 1'b0 || death_image !== 3'd0) begin miscompares++;
      $display("FAIL wait_enter: got vis=%b img=%0d required vis=0 img=0", player_visible, death_image); end
    sofPulse(29);
    vectors++; if (player_visible !== 1'b0 || player_respawn !== 1'b0) begin miscompares++;
      $display("FAIL wait_29: got vis=%b rsp=%b required 0 0", player_visible, player_respawn); end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    vectors++; if ({player_respawn, invulnerable, player_visible} !== 3'b111) begin miscompares++;
      $display("FAIL respawn_pulse: got %b required 111", {player_respawn, invulnerable, player_visible}); end
    step();
    vectors++; if (player_respawn !== 1'b0) begin miscompares++; $display("FAIL respawn_width: got %b required 0", player_respawn); end
  endtask

  task automatic test_ignored();
    pulseDied();
    vectors++; if (lives !== 2'd2 || invulnerable !== 1'b1) begin miscompares++;
      $display("FAIL invuln_hit: got lives=%0d inv=%b required 2 1", lives, invulnerable); end
    pulseStart();
    vectors++; if (player_respawn !== 1'b0 || lives !== 2'd2) begin miscompares++;
      $display("FAIL invuln_start: got rsp=%b lives=%0d required 0 2", player_respawn, lives); end
    sofPulse(90);
    pulseDied();
    vectors++; if (lives !== 2'd1) begin miscompares++; $display("FAIL second_death: got %0d required 1", lives); end
    sofPulse(3);
    pulseDied();
    vectors++; if (lives !== 2'd1 || death_image !== 3'd0) begin miscompares++;
      $display("FAIL dying_hit: got lives=%0d img=%0d required 1 0", lives, death_image); end
    sofPulse(5);
    vectors++; if (death_image !== 3'd1) begin miscompares++; $display("FAIL dying_hit_count: got %0d required 1", death_image); end
    sofPulse(40 + 30 + 90);
    vectors++; if (invulnerable !== 1'b0 || arrows_out !== 4'b1010 || lives !== 2'd1) begin miscompares++;
      $display("FAIL back_playing: got inv=%b arr=%b lives=%0d required 0 1010 1", invulnerable, arrows_out, lives); end
  endtask

  task automatic test_last_life();
    pulseDied();
    vectors++; if (lives !== 2'd0) begin miscompares++; $display("FAIL last_lives: got %0d required 0", lives); end
    sofPulse(47);
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL last_47: got %b required 0", game_over); end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    vectors++; if ({game_over, player_respawn, player_visible, invulnerable} !== 4'b1000) begin miscompares++;
      $display("FAIL game_over_enter: got %b required 1000", {game_over, player_respawn, player_visible, invulnerable}); end
    vectors++; if (arrows_out !== 4'h0 || lives !== 2'd0) begin miscompares++;
      $display("FAIL game_over_state: got arr=%h lives=%0d required 0 0", arrows_out, lives); end
    step();
    sofPulse(5);
    vectors++; if (game_over !== 1'b1 || player_respawn !== 1'b0) begin miscompares++;
      $display("FAIL game_over_hold: got go=%b rsp=%b required 1 0", game_over, player_respawn); end
    pulseStart();
    vectors++; if ({game_over, player_respawn, invulnerable} !== 3'b011 || lives !== 2'd3) begin miscompares++;
      $display("FAIL restart: got %b lives=%0d required 011 3", {game_over, player_respawn, invulnerable}, lives); end
    sofPulse(90);
    vectors++; if (invulnerable !== 1'b0 || arrows_out !== 4'b1010) begin miscompares++;
      $display("FAIL restart_playing: got inv=%b arr=%b required 0 1010", invulnerable, arrows_out); end
  endtask

  task automatic test_same_cycle();
    sofPulse(3);
    player_died = 1'b1;
    startOfFrame = 1'b1;
    step();
    player_died = 1'b0;
    startOfFrame = 1'b0;
    vectors++; if (lives !== 2'd2 || death_image !== 3'd0 || arrows_out !== 4'h0) begin miscompares++;
      $display("FAIL same_cycle_enter: got lives=%0d img=%0d arr=%h required 2 0 0", lives, death_image, arrows_out); end
    step();
    sofPulse(7);
    vectors++; if (death_image !== 3'd0) begin miscompares++; $display("FAIL same_cycle_7: got %0d required 0", death_image); end
    sofPulse(1);
    vectors++; if (death_image !== 3'd1) begin miscompares++; $display("FAIL same_cycle_8: got %0d required 1", death_image); end
  endtask

  task automatic test_mid_reset();
    sofPulse(12);
    vectors++; if (death_image !== 3'd2) begin miscompares++; $display("FAIL frame20_image: got %0d required 2", death_image); end
    resetN = 1'b1;
    step();
    resetN = 1'b0;
    vectors++; if ({player_respawn, player_visible, invulnerable, game_over} !== 4'b0000 || lives !== 2'd0 || death_image !== 3'd0) begin
      miscompares++; $display("FAIL mid_reset: got flags=%b lives=%0d img=%0d required 0000 0 0",
        {player_respawn, player_visible, invulnerable, game_over}, lives, death_image); end
    vectors++; if (arrows_out !== 4'h0) begin miscompares++; $display("FAIL mid_reset_arrows: got %h required 0", arrows_out); end
    sofPulse(5);
    pulseDied();
    step();
    vectors++; if ({player_visible, invulnerable, player_respawn} !== 3'b000 || lives !== 2'd0 || arrows_out !== 4'h0) begin
      miscompares++; $display("FAIL idle_hold: got %b lives=%0d arr=%h required 000 0 0",
        {player_visible, invulnerable, player_respawn}, lives, arrows_out); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_death();
    test_ignored();
    test_last_life();
    test_same_cycle();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
